// File: rtl/ex_muldiv.sv
// RV32IM execute stage: single-cycle ALU/branch/jump plus an optional iterative mul/div unit.
// Define EX_MULDIV_EN to compile in the M-extension FSM; without it codes 38..45 decode as undefined.
module ex_muldiv #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     ins,
  input  logic [XLEN-1:0] ins_addr2ex,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [4:0]      rd_addr2ex,
  input  logic            rd_wen,
  input  logic [6:0]      oh,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_wen2reg,
  output logic [XLEN-1:0] jump_addr2ctrl,
  output logic            jump_en2ctrl,
  output logic            hold2ctrl
);

  localparam logic [6:0] OP_LUI   = 7'd1,  OP_AUIPC = 7'd2,  OP_JAL   = 7'd3,  OP_JALR = 7'd4;
  localparam logic [6:0] OP_BEQ   = 7'd5,  OP_BNE   = 7'd6,  OP_BLT   = 7'd7,  OP_BGE  = 7'd8;
  localparam logic [6:0] OP_BLTU  = 7'd9,  OP_BGEU  = 7'd10;
  localparam logic [6:0] OP_ADDI  = 7'd19, OP_SLTI  = 7'd20, OP_SLTIU = 7'd21, OP_XORI = 7'd22;
  localparam logic [6:0] OP_ORI   = 7'd23, OP_ANDI  = 7'd24, OP_SLLI  = 7'd25, OP_SRLI = 7'd26;
  localparam logic [6:0] OP_SRAI  = 7'd27, OP_ADD   = 7'd28, OP_SUB   = 7'd29, OP_SLL  = 7'd30;
  localparam logic [6:0] OP_SLT   = 7'd31, OP_SLTU  = 7'd32, OP_XOR   = 7'd33, OP_SRL  = 7'd34;
  localparam logic [6:0] OP_SRA   = 7'd35, OP_OR    = 7'd36, OP_AND   = 7'd37;
  localparam logic [6:0] OP_MFIRST = 7'd38, OP_MLAST = 7'd45;

  // immediates are built at 32 bits and sign-extended/truncated to XLEN
  logic [31:0] imm_u32, imm_j32, imm_b32;
  assign imm_u32 = {ins[31:12], 12'b0};
  assign imm_j32 = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
  assign imm_b32 = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};

  logic [XLEN-1:0] imm_u, imm_j, imm_b;
  assign imm_u = XLEN'($signed(imm_u32));
  assign imm_j = XLEN'($signed(imm_j32));
  assign imm_b = XLEN'($signed(imm_b32));

  logic unused_ins;
  assign unused_ins = ^ins[6:0];

  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] sum, diff_s, pc4, sra_res;
  logic            lt_s, lt_u, eq;
  assign shamt   = op2[SHW-1:0];
  assign sum     = op1 + op2;
  assign diff_s  = op1 - op2;
  assign pc4     = ins_addr2ex + XLEN'(4);
  assign sra_res = $unsigned($signed(op1) >>> shamt);
  assign lt_s    = $signed(op1) < $signed(op2);
  assign lt_u    = op1 < op2;
  assign eq      = op1 == op2;

  // single-cycle result, before masking by the M unit
  logic [XLEN-1:0] s_data, s_jaddr;
  logic [4:0]      s_addr;
  logic            s_wen, s_jen, s_wb;

  always_comb begin
    s_data  = '0;
    s_jaddr = '0;
    s_jen   = 1'b0;
    s_wb    = 1'b0;
    case (oh)
      OP_LUI:   begin s_wb = 1'b1; s_data = imm_u; end
      OP_AUIPC: begin s_wb = 1'b1; s_data = ins_addr2ex + imm_u; end
      OP_JAL:   begin s_wb = 1'b1; s_data = pc4; s_jen = 1'b1; s_jaddr = ins_addr2ex + imm_j; end
      OP_JALR:  begin s_wb = 1'b1; s_data = pc4; s_jen = 1'b1; s_jaddr = {sum[XLEN-1:1], 1'b0}; end
      OP_BEQ:   begin s_jen = eq;    s_jaddr = ins_addr2ex + imm_b; end
      OP_BNE:   begin s_jen = !eq;   s_jaddr = ins_addr2ex + imm_b; end
      OP_BLT:   begin s_jen = lt_s;  s_jaddr = ins_addr2ex + imm_b; end
      OP_BGE:   begin s_jen = !lt_s; s_jaddr = ins_addr2ex + imm_b; end
      OP_BLTU:  begin s_jen = lt_u;  s_jaddr = ins_addr2ex + imm_b; end
      OP_BGEU:  begin s_jen = !lt_u; s_jaddr = ins_addr2ex + imm_b; end
      OP_ADDI, OP_ADD:   begin s_wb = 1'b1; s_data = sum; end
      OP_SUB:            begin s_wb = 1'b1; s_data = diff_s; end
      OP_SLTI, OP_SLT:   begin s_wb = 1'b1; s_data = XLEN'(lt_s); end
      OP_SLTIU, OP_SLTU: begin s_wb = 1'b1; s_data = XLEN'(lt_u); end
      OP_XORI, OP_XOR:   begin s_wb = 1'b1; s_data = op1 ^ op2; end
      OP_ORI, OP_OR:     begin s_wb = 1'b1; s_data = op1 | op2; end
      OP_ANDI, OP_AND:   begin s_wb = 1'b1; s_data = op1 & op2; end
      OP_SLLI, OP_SLL:   begin s_wb = 1'b1; s_data = op1 << shamt; end
      OP_SRLI, OP_SRL:   begin s_wb = 1'b1; s_data = op1 >> shamt; end
      OP_SRAI, OP_SRA:   begin s_wb = 1'b1; s_data = sra_res; end
      default: ;
    endcase
  end

  assign s_addr = s_wb ? rd_addr2ex : 5'd0;
  assign s_wen  = s_wb & rd_wen;

`ifdef EX_MULDIV_EN
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [1:0] S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2;
  localparam logic [2:0] K_MUL = 3'd0, K_MULH = 3'd1, K_MULHSU = 3'd2, K_MULHU = 3'd3;
  localparam logic [2:0] K_DIV = 3'd4, K_DIVU = 3'd5, K_REM = 3'd6, K_REMU = 3'd7;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] prod;   // mul: {hi acc, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   dvs;    // multiplicand or divisor magnitude
  logic [2:0]        kind;
  logic              neg, spec;

  logic            is_m, sg1, sg2, s1, s2, div_zero, div_ovf;
  logic [2:0]      m_kind;
  logic [XLEN-1:0] m1, m2;
  assign is_m     = (oh >= OP_MFIRST) && (oh <= OP_MLAST);
  assign m_kind   = 3'(oh - OP_MFIRST);
  assign sg1      = m_kind == K_MULH || m_kind == K_MULHSU || m_kind == K_DIV || m_kind == K_REM;
  assign sg2      = m_kind == K_MULH || m_kind == K_DIV || m_kind == K_REM;
  assign s1       = sg1 & op1[XLEN-1];
  assign s2       = sg2 & op2[XLEN-1];
  assign m1       = s1 ? -op1 : op1;
  assign m2       = s2 ? -op2 : op2;
  assign div_zero = m_kind[2] && (op2 == '0);
  assign div_ovf  = (m_kind == K_DIV || m_kind == K_REM) &&
                    (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);

  logic [XLEN:0] mac, trial, dtry;
  assign mac   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, dvs} : {(XLEN+1){1'b0}});
  assign trial = prod[2*XLEN-1:XLEN-1];
  assign dtry  = trial - {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      prod  <= '0;
      dvs   <= '0;
      kind  <= '0;
      neg   <= 1'b0;
      spec  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (is_m) begin
          kind <= m_kind;
          cnt  <= CW'(XLEN);
          dvs  <= m2;
          neg  <= (m_kind == K_REM || m_kind == K_REMU) ? s1 : (s1 ^ s2);
          if (div_zero || div_ovf) begin
            spec  <= 1'b1;
            state <= S_DONE;
            if (div_zero) prod <= {{XLEN{1'b0}}, m_kind[1] ? op1 : {XLEN{1'b1}}};
            else          prod <= {{XLEN{1'b0}}, m_kind[1] ? {XLEN{1'b0}} : op1};
          end else begin
            spec  <= 1'b0;
            state <= S_CALC;
            prod  <= {{XLEN{1'b0}}, m1};
          end
        end
        S_CALC: begin
          if (!kind[2])
            prod <= {mac, prod[XLEN-1:1]};
          else if (!dtry[XLEN])
            prod <= {dtry[XLEN-1:0], prod[XLEN-2:0], 1'b1};
          else
            prod <= {trial[XLEN-1:0], prod[XLEN-2:0], 1'b0};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [2*XLEN-1:0] full;
  logic [XLEN-1:0]   quo, rem, m_res;
  assign full = neg ? -prod : prod;
  assign quo  = neg ? -prod[XLEN-1:0] : prod[XLEN-1:0];
  assign rem  = neg ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];

  always_comb begin
    m_res = '0;
    if (spec) m_res = prod[XLEN-1:0];
    else case (kind)
      K_MUL:                    m_res = full[XLEN-1:0];
      K_MULH, K_MULHSU, K_MULHU: m_res = full[2*XLEN-1:XLEN];
      K_DIV, K_DIVU:            m_res = quo;
      default:                  m_res = rem;
    endcase
  end

  always_comb begin
    rd_addr        = '0;
    rd_data        = '0;
    rd_wen2reg     = 1'b0;
    jump_addr2ctrl = '0;
    jump_en2ctrl   = 1'b0;
    hold2ctrl      = 1'b0;
    if (rst_n) begin
      case (state)
        S_IDLE: begin
          if (is_m) hold2ctrl = 1'b1;
          else begin
            rd_addr        = s_addr;
            rd_data        = s_data;
            rd_wen2reg     = s_wen;
            jump_addr2ctrl = s_jaddr;
            jump_en2ctrl   = s_jen;
          end
        end
        S_CALC: hold2ctrl = 1'b1;
        S_DONE: begin
          rd_addr    = rd_addr2ex;
          rd_data    = m_res;
          rd_wen2reg = rd_wen;
        end
        default: ;
      endcase
    end
  end
`else
  logic unused_ctl;
  assign unused_ctl     = clk ^ rst_n;
  assign rd_addr        = s_addr;
  assign rd_data        = s_data;
  assign rd_wen2reg     = s_wen;
  assign jump_addr2ctrl = s_jaddr;
  assign jump_en2ctrl   = s_jen;
  assign hold2ctrl      = 1'b0;
`endif

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv; M-extension sequences follow the EX_MULDIV_EN build option.
module tb_ex_muldiv;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [31:0]     ins;
  logic [XLEN-1:0] ins_addr2ex, op1, op2;
  logic [4:0]      rd_addr2ex;
  logic            rd_wen;
  logic [6:0]      oh;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_data, jump_addr2ctrl;
  logic            rd_wen2reg, jump_en2ctrl, hold2ctrl;

  int n_asrt = 0;
  int n_fail = 0;

  ex_muldiv #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .ins(ins), .ins_addr2ex(ins_addr2ex),
    .op1(op1), .op2(op2), .rd_addr2ex(rd_addr2ex), .rd_wen(rd_wen), .oh(oh),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_wen2reg(rd_wen2reg),
    .jump_addr2ctrl(jump_addr2ctrl), .jump_en2ctrl(jump_en2ctrl), .hold2ctrl(hold2ctrl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [6:0] code, input logic [31:0] a, input logic [31:0] b);
    oh  = code;
    op1 = a;
    op2 = b;
    #1;
  endtask

  // runs one M op from accept to the cycle after DONE
  task automatic m_run(input string tag, input logic [6:0] code, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_hold);
    int hc;
    hc = 0;
    set_op(code, a, b);
    for (int i = 0; i < 100 && hold2ctrl; i++) begin
      hc++;
      step();
    end
    chk({tag, "_hold"}, hc, exp_hold);
    chk({tag, "_data"}, rd_data, exp);
    chk({tag, "_wen"}, {31'b0, rd_wen2reg}, 32'd1);
    chk({tag, "_addr"}, {27'b0, rd_addr}, 32'd9);
    oh = 7'd0;
    step();
    chk({tag, "_once"}, {31'b0, rd_wen2reg}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; ins = 32'h0; ins_addr2ex = 32'h0; op1 = 0; op2 = 0;
    rd_addr2ex = 5'd9; rd_wen = 1'b1; oh = 7'd0;
    step(); step();
    chk("rst_hold", {31'b0, hold2ctrl}, 32'd0);
    chk("rst_data", rd_data, 32'd0);
    chk("rst_wen",  {31'b0, rd_wen2reg}, 32'd0);
    chk("rst_jen",  {31'b0, jump_en2ctrl}, 32'd0);
`ifdef EX_MULDIV_EN
    set_op(7'd19, 32'd5, 32'd1);
    chk("rst_mask", rd_data, 32'd0);
    oh = 7'd0;
`endif
    rst_n = 1'b1;
    step();

    set_op(7'd19, 32'd5, -32'sd7);
    chk("addi_data", rd_data, 32'hFFFF_FFFE);
    chk("addi_wen", {31'b0, rd_wen2reg}, 32'd1);
    chk("addi_addr", {27'b0, rd_addr}, 32'd9);
    chk("addi_hold", {31'b0, hold2ctrl}, 32'd0);
    set_op(7'd35, 32'h8000_0000, 32'd4);
    chk("sra", rd_data, 32'hF800_0000);
    set_op(7'd34, 32'h8000_0000, 32'd4);
    chk("srl", rd_data, 32'h0800_0000);
    set_op(7'd29, 32'd3, 32'd5);
    chk("sub", rd_data, 32'hFFFF_FFFE);
    set_op(7'd31, 32'hFFFF_FFFF, 32'd1);
    chk("slt", rd_data, 32'd1);
    set_op(7'd32, 32'hFFFF_FFFF, 32'd1);
    chk("sltu", rd_data, 32'd0);

    ins_addr2ex = 32'h100;
    set_op(7'd4, 32'h203, 32'h0);
    chk("jalr_addr", jump_addr2ctrl, 32'h202);
    chk("jalr_en", {31'b0, jump_en2ctrl}, 32'd1);
    chk("jalr_data", rd_data, 32'h104);

    ins = 32'h1234_5037;
    set_op(7'd1, 32'h0, 32'h0);
    chk("lui", rd_data, 32'h1234_5000);
    set_op(7'd2, 32'h0, 32'h0);
    chk("auipc", rd_data, 32'h1234_5100);

    ins = 32'h0000_0463;
    set_op(7'd5, 32'd7, 32'd7);
    chk("beq_en", {31'b0, jump_en2ctrl}, 32'd1);
    chk("beq_addr", jump_addr2ctrl, 32'h108);
    chk("beq_wen", {31'b0, rd_wen2reg}, 32'd0);
    set_op(7'd6, 32'd7, 32'd7);
    chk("bne_en", {31'b0, jump_en2ctrl}, 32'd0);

    set_op(7'd18, 32'd1, 32'd2);
    chk("sw_wen", {31'b0, rd_wen2reg}, 32'd0);
    chk("sw_jen", {31'b0, jump_en2ctrl}, 32'd0);
    set_op(7'd60, 32'd1, 32'd2);
    chk("undef_data", rd_data, 32'd0);
    chk("undef_addr", {27'b0, rd_addr}, 32'd0);
    step();

`ifdef EX_MULDIV_EN
    m_run("mulh",  7'd39, -32'sd3, 32'd7, 32'hFFFF_FFFF, 33);
    m_run("mul",   7'd38, -32'sd3, 32'd7, 32'hFFFF_FFEB, 33);
    m_run("mulhu", 7'd41, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    m_run("div",   7'd42, -32'sd7, 32'd2, 32'hFFFF_FFFD, 33);
    m_run("rem",   7'd44, -32'sd7, 32'd2, 32'hFFFF_FFFF, 33);
    m_run("divu0", 7'd43, 32'd7, 32'd0, 32'hFFFF_FFFF, 1);
    m_run("remu0", 7'd45, 32'd7, 32'd0, 32'd7, 1);
    m_run("divov", 7'd42, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    m_run("remov", 7'd44, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    set_op(7'd39, -32'sd3, 32'd7);
    for (int i = 0; i < 10; i++) step();
    chk("calc_hold", {31'b0, hold2ctrl}, 32'd1);
    rst_n = 1'b0;
    oh    = 7'd0;
    #1;
    chk("rstc_hold", {31'b0, hold2ctrl}, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("rstc_idle", {31'b0, hold2ctrl}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("rstc_nowb", {31'b0, rd_wen2reg}, 32'd0);
      step();
    end
    m_run("divu", 7'd43, 32'd100, 32'd7, 32'd14, 33);
`else
    set_op(7'd39, -32'sd3, 32'd7);
    chk("moff_hold", {31'b0, hold2ctrl}, 32'd0);
    chk("moff_data", rd_data, 32'd0);
    chk("moff_wen", {31'b0, rd_wen2reg}, 32'd0);
    step();
    chk("moff_hold2", {31'b0, hold2ctrl}, 32'd0);
    set_op(7'd42, 32'd100, 32'd7);
    chk("moff_div", rd_data, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
